barcode_tx: RTL and testbench

Sequencer that converts a stream of bar/space symbols into timed sink-enable codes for the `barcode_driver` open-drain pad. It replays a barcode pattern optically through an LED or pad sink. Symbols arrive over a valid/ready handshake. Each symbol is held for an integer number of module periods, and `ng_en[3:0]` is driven with a programmed strength during bars and all-zero during spaces. The block sits between the register/CPU side and the `barcode_driver` instance.

---
 rtl/barcode_pkg.sv | 43 ++++
 rtl/barcode_tx_if.sv | 32 +++
 rtl/barcode_mod_timer.sv | 45 ++++
 rtl/barcode_tx.sv | 197 +++++++++++++++++++
 tb/tb_barcode_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/barcode_pkg.sv
// -----------------------------------------------------------------------------
// barcode_pkg
// Shared types and constants for the barcode transmit sequencer.
//   state_t      : sequencer states (IDLE / RUN / STOP)
//   SYM_BAR_BIT  : position of the bar/space flag in a default-width symbol
//   NG_OFF       : sink-enable code that turns every pad sink off
//   RAMP_MASK_*  : per-step masks applied to the strength code during a ramp
//   ramp_mask()  : maps a ramp step (0..3) to its mask
//   DIV_W_DEF / WID_W_DEF : default divider and module-count widths
// -----------------------------------------------------------------------------
package barcode_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int WID_W_DEF = 7;

    // The bar flag sits directly above the width field.
    localparam int SYM_BAR_BIT = WID_W_DEF;

    localparam logic [3:0] NG_OFF = 4'b0000;

    localparam logic [3:0] RAMP_MASK_0 = 4'b0001;
    localparam logic [3:0] RAMP_MASK_1 = 4'b0011;
    localparam logic [3:0] RAMP_MASK_2 = 4'b0111;
    localparam logic [3:0] RAMP_MASK_3 = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    function automatic logic [3:0] ramp_mask(input logic [1:0] step);
        logic [3:0] mask;
        case (step)
            2'd0:    mask = RAMP_MASK_0;
            2'd1:    mask = RAMP_MASK_1;
            2'd2:    mask = RAMP_MASK_2;
            default: mask = RAMP_MASK_3;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/barcode_tx_if.sv
// -----------------------------------------------------------------------------
// barcode_tx_if
// Symbol stream handshake into the barcode sequencer.
//   sym_valid : source has a symbol on sym_data
//   sym_ready : sequencer accepts the symbol this cycle (valid && ready)
//   sym_data  : [WID_W] = 1 bar / 0 space, [WID_W-1:0] = width in modules,
//               width 0 marks end-of-frame
// Modports: master = symbol source, slave = sequencer.
// -----------------------------------------------------------------------------
interface barcode_tx_if
    import barcode_pkg::*;
#(
    parameter int WID_W = WID_W_DEF
) ();

    logic             sym_valid;
    logic             sym_ready;
    logic [WID_W:0]   sym_data;

    modport master (
        output sym_valid,
        output sym_data,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_data,
        output sym_ready
    );

endinterface

// File: rtl/barcode_mod_timer.sv
// -----------------------------------------------------------------------------
// barcode_mod_timer
// Module-period prescaler. Counts 0..period and flags the final cycle of
// each module period.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : frame start; captures mod_div as the period, count restarts
//   run        : count while high; count is held at 0 while low
//   mod_div    : module period minus one, in clk cycles
//   tick       : high in the last cycle of a module period (count == period)
// -----------------------------------------------------------------------------
module barcode_mod_timer
    import barcode_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] mod_div,
    output logic             tick
);

    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] cnt_q;

    assign tick = (cnt_q == period_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= mod_div;
            cnt_q    <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/barcode_tx.sv
// -----------------------------------------------------------------------------
// barcode_tx
// Replays a stream of bar/space symbols as timed sink-enable codes for the
// barcode_driver open-drain pad. Each symbol lasts width x (mod_div+1) clk
// cycles; ng_en carries the latched strength during bars and NG_OFF during
// spaces.
//   clk, rst_n : clock, asynchronous active-low reset
//   mod_div    : module period minus one (latched at frame start)
//   strength   : ng_en code used for bars (latched at frame start)
//   sym        : symbol handshake (barcode_tx_if.slave)
//   ng_en      : registered sink enables to barcode_driver.ng_en
//   busy       : frame in progress (RUN or STOP)
//   done       : one-cycle pulse at normal frame end
//   underrun   : one-cycle pulse when a frame aborts for lack of a symbol
// Build option: define BARCODE_TX_RAMP_EN to step ng_en up through
// 0001/0011/0111/1111 masks on every idle->bar or space->bar transition.
// -----------------------------------------------------------------------------
module barcode_tx
    import barcode_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int WID_W = WID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] mod_div,
    input  logic [3:0]       strength,
    barcode_tx_if.slave      sym,
    output logic [3:0]       ng_en,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int BAR_BIT = SYM_BAR_BIT + (WID_W - WID_W_DEF);

    // Incoming symbol fields.
    logic             bar_in;
    logic [WID_W-1:0] width_in;
    logic             eof_in;

    assign bar_in   = sym.sym_data[BAR_BIT];
    assign width_in = sym.sym_data[WID_W-1:0];
    assign eof_in   = (width_in == '0);

    // State and registered outputs.
    state_t           state_q, state_d;
    logic             bar_q, bar_d;
    logic [WID_W-1:0] wid_q, wid_d;
    logic [3:0]       str_q, str_d;
    logic [3:0]       ng_q, ng_d;
    logic             done_q, done_d;
    logic             und_q, und_d;

    logic             timer_load;
    logic             timer_run;
    logic             tick;
    logic             last;

`ifdef BARCODE_TX_RAMP_EN
    logic [1:0]       ramp_q, ramp_d;
`endif

    barcode_mod_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .run     (timer_run),
        .mod_div (mod_div),
        .tick    (tick)
    );

    // Final cycle of the current symbol: last module, divider at its period.
    assign last = (state_q == ST_RUN) && tick && (wid_q == WID_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bar_q   <= 1'b0;
            wid_q   <= '0;
            str_q   <= NG_OFF;
            ng_q    <= NG_OFF;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
`ifdef BARCODE_TX_RAMP_EN
            ramp_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            wid_q   <= wid_d;
            str_q   <= str_d;
            ng_q    <= ng_d;
            done_q  <= done_d;
            und_q   <= und_d;
`ifdef BARCODE_TX_RAMP_EN
            ramp_q  <= ramp_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        bar_d         = bar_q;
        wid_d         = wid_q;
        str_d         = str_q;
        done_d        = 1'b0;
        und_d         = 1'b0;
        timer_load    = 1'b0;
        timer_run     = 1'b0;
        sym.sym_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sym.sym_ready = 1'b1;
                if (sym.sym_valid) begin
                    if (eof_in) begin
                        // Empty frame: report completion without starting.
                        done_d = 1'b1;
                    end else begin
                        str_d      = strength;
                        bar_d      = bar_in;
                        wid_d      = width_in;
                        timer_load = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                timer_run = 1'b1;
                if (last) begin
                    sym.sym_ready = 1'b1;
                    if (!sym.sym_valid) begin
                        und_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (eof_in) begin
                        done_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // The divider wraps to 0 on its own, so the next
                        // symbol starts with no gap.
                        bar_d = bar_in;
                        wid_d = width_in;
                    end
                end else if (tick) begin
                    wid_d = wid_q - 1'b1;
                end
            end

            ST_STOP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ng_en is computed from the next state so the register shows the new
    // symbol's level in the very first cycle after the accept.
`ifdef BARCODE_TX_RAMP_EN
    always_comb begin
        // Continue the ramp only while a bar is already being shown, so
        // bar->bar transitions do not restart it.
        if ((state_q == ST_RUN) && bar_q) begin
            ramp_d = (ramp_q == 2'd3) ? 2'd3 : ramp_q + 2'd1;
        end else begin
            ramp_d = 2'd0;
        end
        if ((state_d == ST_RUN) && bar_d) begin
            ng_d = str_d & ramp_mask(ramp_d);
        end else begin
            ng_d = NG_OFF;
        end
    end
`else
    always_comb begin
        if ((state_d == ST_RUN) && bar_d) begin
            ng_d = str_d;
        end else begin
            ng_d = NG_OFF;
        end
    end
`endif

    assign ng_en    = ng_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_barcode_tx.sv
// -----------------------------------------------------------------------------
// tb_barcode_tx
// Directed self-checking bench for barcode_tx. Each frame is driven from a
// symbol list; the expected per-cycle ng_en/busy/done/underrun trace is built
// from the symbol widths, mod_div and strength, then compared against a trace
// captured on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_barcode_tx;
    import barcode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mod_div;
    logic [3:0]  strength;
    logic [3:0]  ng_en;
    logic        busy;
    logic        done;
    logic        underrun;

    barcode_tx_if #(.WID_W(WID_W_DEF)) sym_if ();

    barcode_tx #(
        .DIV_W (DIV_W_DEF),
        .WID_W (WID_W_DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mod_div  (mod_div),
        .strength (strength),
        .sym      (sym_if),
        .ng_en    (ng_en),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Symbol list for the frame being driven: {bar, width[6:0]}.
    logic [7:0] stim_q[$];

    function automatic logic [7:0] sym(input bit b, input int w);
        return {b, 7'(w)};
    endfunction

    // Captured trace.
    bit         cap_en = 1'b0;
    logic [3:0] cap_ng[$];
    logic       cap_busy[$];
    logic       cap_done[$];
    logic       cap_und[$];

    always @(negedge clk) begin
        if (cap_en) begin
            cap_ng.push_back(ng_en);
            cap_busy.push_back(busy);
            cap_done.push_back(done);
            cap_und.push_back(underrun);
        end
    end

    // Expected trace; index 0 is the cycle in which the first symbol is accepted.
    logic [3:0] exp_ng[$];
    logic       exp_busy[$];
    logic       exp_done[$];
    logic       exp_und[$];

    task automatic push_exp(input logic [3:0] n, input logic b, input logic d, input logic u);
        exp_ng.push_back(n);
        exp_busy.push_back(b);
        exp_done.push_back(d);
        exp_und.push_back(u);
    endtask

    task automatic build_expect(input logic [15:0] div, input logic [3:0] str);
        bit eof;
        int ncyc;
`ifdef BARCODE_TX_RAMP_EN
        int step;
        step = 0;
`endif
        exp_ng.delete();
        exp_busy.delete();
        exp_done.delete();
        exp_und.delete();
        push_exp(4'b0000, 1'b0, 1'b0, 1'b0);
        if (stim_q[0][6:0] == 7'd0) begin
            push_exp(4'b0000, 1'b0, 1'b1, 1'b0);
            push_exp(4'b0000, 1'b0, 1'b0, 1'b0);
            return;
        end
        eof = 1'b0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (stim_q[i][6:0] == 7'd0) begin
                eof = 1'b1;
                break;
            end
            ncyc = int'(stim_q[i][6:0]) * (int'(div) + 1);
            for (int k = 0; k < ncyc; k++) begin
                if (stim_q[i][7]) begin
`ifdef BARCODE_TX_RAMP_EN
                    push_exp(str & 4'((1 << (step + 1)) - 1), 1'b1, 1'b0, 1'b0);
                    if (step < 3) step++;
`else
                    push_exp(str, 1'b1, 1'b0, 1'b0);
`endif
                end else begin
                    push_exp(4'b0000, 1'b1, 1'b0, 1'b0);
`ifdef BARCODE_TX_RAMP_EN
                    step = 0;
`endif
                end
            end
        end
        push_exp(4'b0000, 1'b1, eof, !eof);
        push_exp(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Drives stim_q as one frame and compares the captured trace.
    // Called and returns one time unit after a rising edge.
    task automatic send_frame(input string name, input logic [15:0] div, input logic [3:0] str);
        bit accepted;
        bit idle_seen;
        build_expect(div, str);
        cap_ng.delete();
        cap_busy.delete();
        cap_done.delete();
        cap_und.delete();
        mod_div  = div;
        strength = str;
        cap_en   = 1'b1;
        for (int i = 0; i < stim_q.size(); i++) begin
            sym_if.sym_valid = 1'b1;
            sym_if.sym_data  = stim_q[i];
            accepted = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (sym_if.sym_ready) begin
                    accepted = 1'b1;
                    break;
                end
            end
            check($sformatf("%s_accept%0d", name, i), 32'(accepted), 32'd1);
            if (!accepted) break;
            @(posedge clk);
            #1;
            // Inputs changed mid-frame must not affect this frame.
            if (i == 0) begin
                mod_div  = ~div;
                strength = ~str;
            end
        end
        sym_if.sym_valid = 1'b0;
        sym_if.sym_data  = '0;
        idle_seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, 32'(idle_seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        cap_en = 1'b0;
        check({name, "_len"}, 32'(cap_ng.size() >= exp_ng.size()), 32'd1);
        for (int i = 0; i < exp_ng.size() && i < cap_ng.size(); i++) begin
            check($sformatf("%s_ng[%0d]", name, i),   32'(cap_ng[i]),   32'(exp_ng[i]));
            check($sformatf("%s_busy[%0d]", name, i), 32'(cap_busy[i]), 32'(exp_busy[i]));
            check($sformatf("%s_done[%0d]", name, i), 32'(cap_done[i]), 32'(exp_done[i]));
            check($sformatf("%s_und[%0d]", name, i),  32'(cap_und[i]),  32'(exp_und[i]));
        end
    endtask

    initial begin
        // Reset with a valid symbol waiting: nothing may be accepted.
        rst_n            = 1'b0;
        mod_div          = 16'd3;
        strength         = 4'b1010;
        sym_if.sym_valid = 1'b1;
        sym_if.sym_data  = 8'h85;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ng",       32'(ng_en),            32'h0);
        check("rst_busy",     32'(busy),             32'h0);
        check("rst_ready",    32'(sym_if.sym_ready), 32'h1);
        check("rst_done",     32'(done),             32'h0);
        check("rst_underrun", 32'(underrun),         32'h0);
        sym_if.sym_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'h0);

        // Main frame: bar 2, space 1, bar 3, end.
        stim_q = '{sym(1, 2), sym(0, 1), sym(1, 3), sym(0, 0)};
        send_frame("frame_a", 16'd3, 4'b1010);

        // Back-to-back single-module bars at mod_div 0.
        stim_q = '{sym(1, 1), sym(1, 1), sym(0, 0)};
        send_frame("b2b", 16'd0, 4'b1010);

        // Underrun: no symbol offered after the first one ends.
        stim_q = '{sym(1, 2)};
        send_frame("under", 16'd1, 4'b0110);
        @(negedge clk);
        check("under_ready_after", 32'(sym_if.sym_ready), 32'h1);
        check("under_busy_after",  32'(busy),             32'h0);
        @(posedge clk);
        #1;

        // Empty frame accepted in IDLE.
        stim_q = '{sym(0, 0)};
        send_frame("empty", 16'd5, 4'b1111);

        // Full strength, two-module bar at mod_div 3.
        stim_q = '{sym(1, 2), sym(0, 0)};
        send_frame("full", 16'd3, 4'b1111);

        // Mixed widths including a short bar, a space, and bar->bar.
        stim_q = '{sym(1, 1), sym(0, 1), sym(1, 2), sym(1, 1), sym(0, 0)};
        send_frame("mixed", 16'd2, 4'b1011);

        // Reset in the middle of a long bar.
        mod_div          = 16'd3;
        strength         = 4'b1111;
        sym_if.sym_valid = 1'b1;
        sym_if.sym_data  = sym(1, 10);
        @(negedge clk);
        @(posedge clk);
        #1;
        sym_if.sym_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_bar_ng",   32'(ng_en), 32'hf);
        check("mid_bar_busy", 32'(busy),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ng",    32'(ng_en),            32'h0);
        check("async_rst_busy",  32'(busy),             32'h0);
        check("async_rst_ready", 32'(sym_if.sym_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean frame after reset with a new mod_div.
        stim_q = '{sym(0, 1), sym(1, 2), sym(0, 0)};
        send_frame("after_rst", 16'd1, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
